res_drain: RTL

- Downstream consumer of the result memory (RAM C, 64-bit words written by the controller/ALU path).
- On a start pulse, reads a programmed number of consecutive result words from RAM C through its read port.
- Buffers the words in a small FIFO and serialises each word into bytes on a valid/ready byte stream, for a UART/debug-link or checker.
- Runs on the same clock domain as the RAM C port and the controller.

---
 rtl/res_drain.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/res_drain.sv
// Result-memory drain: reads a run of RAM C words, buffers them in a small FIFO
// and serialises each word LSB-first onto a valid/ready byte stream.
module res_drain #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    output logic              busy,
    output logic              done,
    output logic              mem_c_rd,
    output logic [ADDR_W-1:0] mem_c_addr,
    input  logic [DATA_W-1:0] mem_c_data,
    output logic [7:0]        byte_data,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              byte_last
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NB - 1);
    localparam logic [ADDR_W:0]   ONE_W    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   ZERO_W   = '0;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_READ   = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   rd_left;
    logic [ADDR_W:0]   out_left;
    logic              vld_p1;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;

    logic [DATA_W-1:0] hold_word_p2;
    logic              vld_p2;
    logic              hold_last;
    logic [IDX_W-1:0]  byte_idx;

    logic [CNT_W-1:0]  credit_used;
    logic              issue;
    logic              xfer;
    logic              last_byte;
    logic              hold_free;
    logic              fifo_empty;
    logic              fifo_rd;
    logic              fifo_wr;
    logic              bypass;
    logic              hold_load;

    always_comb begin
        credit_used = fifo_count + CNT_W'(vld_p1);
        issue       = (state == S_READ) && (credit_used < DEPTH_C);
        xfer        = vld_p2 && byte_ready;
        last_byte   = (byte_idx == LAST_IDX);
        hold_free   = !vld_p2 || (xfer && last_byte);
        fifo_empty  = (fifo_count == '0);
        fifo_rd     = hold_free && !fifo_empty;
        // Returning data skips the FIFO when nothing is queued ahead of it.
        bypass      = vld_p1 && fifo_empty && hold_free;
        fifo_wr     = vld_p1 && !bypass;
        hold_load   = fifo_rd || bypass;
    end

    assign busy       = (state != S_IDLE);
    assign done       = (state == S_FINISH);
    assign mem_c_rd   = issue;
    assign mem_c_addr = rd_addr;
    assign byte_valid = vld_p2;
    assign byte_data  = vld_p2 ? hold_word_p2[7:0] : 8'h00;
    assign byte_last  = vld_p2 && hold_last && last_byte;

    // Stage p0: FSM and read issue
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            rd_addr  <= '0;
            rd_left  <= '0;
            out_left <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rd_addr  <= base_addr;
                        rd_left  <= num_words;
                        out_left <= num_words;
                        state    <= (num_words == ZERO_W) ? S_FINISH : S_READ;
                    end
                end
                S_READ: begin
                    if (issue) begin
                        rd_addr <= rd_addr + 1'b1;
                        rd_left <= rd_left - ONE_W;
                        if (rd_left == ONE_W) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty && !vld_p1 && xfer && byte_last) state <= S_FINISH;
                end
                default: state <= S_IDLE;
            endcase
            if (hold_load) out_left <= out_left - ONE_W;
        end
    end

    // Stage p1: RAM C data returns and lands in the FIFO or the holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            vld_p1 <= issue;
            if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_wr, fifo_rd})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) fifo_mem[wr_ptr] <= mem_c_data;
    end

    // Stage p2: holding register shifts out one byte per accepted transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2    <= 1'b0;
            hold_last <= 1'b0;
            byte_idx  <= '0;
        end else begin
            if (hold_load) begin
                vld_p2    <= 1'b1;
                hold_last <= (out_left == ONE_W);
                byte_idx  <= '0;
            end else if (xfer) begin
                if (last_byte) vld_p2 <= 1'b0;
                byte_idx <= byte_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hold_load)
            hold_word_p2 <= bypass ? mem_c_data : fifo_mem[rd_ptr];
        else if (xfer)
            hold_word_p2 <= hold_word_p2 >> 8;
    end

endmodule
